// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register: ALU op encodings,
// the default register-index width and the immediate extension helper.
package id_ex_stage_pkg;

   localparam int DEF_REG_IDX_W = 4;

   typedef enum logic [1:0] {
      ALU_Add = 2'd0,
      ALU_Sub = 2'd1,
      ALU_And = 2'd2
   } alu_op_e;

   function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sign_ext);
      return sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
   endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Per-source operand resolve: R0 reads zero, the MEM-stage result beats the
// WB-stage result, and the register file is the fallback.
module operand_fwd_mux #(
   parameter int REG_IDX_W = 4
) (
   input  logic [REG_IDX_W-1:0] rs_idx,
   input  logic [31:0]          rf_data,
   input  logic                 fwd_mem_en,
   input  logic [REG_IDX_W-1:0] fwd_mem_rd,
   input  logic [31:0]          fwd_mem_data,
   input  logic                 fwd_wb_en,
   input  logic [REG_IDX_W-1:0] fwd_wb_rd,
   input  logic [31:0]          fwd_wb_data,
   output logic [31:0]          operand
);

   always_comb begin
      operand = rf_data;
      if (rs_idx == '0) begin
         operand = 32'h0;
      end else if (fwd_mem_en && (fwd_mem_rd == rs_idx)) begin
         operand = fwd_mem_data;
      end else if (fwd_wb_en && (fwd_wb_rd == rs_idx)) begin
         operand = fwd_wb_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded operands, detects load-use
// hazards, and holds the ALU operands/controls under a valid/ready handshake.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int REG_IDX_W = DEF_REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_alu_op,
   input  logic [REG_IDX_W-1:0] in_rs1,
   input  logic [REG_IDX_W-1:0] in_rs2,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic [31:0]          in_rs1_data,
   input  logic [31:0]          in_rs2_data,
   input  logic [15:0]          in_imm,
   input  logic                 in_use_imm,
   input  logic                 in_sign_ext,
   input  logic                 in_wb_en,
   input  logic                 in_is_load,
   input  logic                 flush,
   input  logic                 fwd_mem_en,
   input  logic [REG_IDX_W-1:0] fwd_mem_rd,
   input  logic [31:0]          fwd_mem_data,
   input  logic                 fwd_wb_en,
   input  logic [REG_IDX_W-1:0] fwd_wb_rd,
   input  logic [31:0]          fwd_wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          alu_in1,
   output logic [31:0]          alu_in2,
   output logic [1:0]           alu_op,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic                 out_wb_en,
   output logic                 out_is_load,
   output logic [15:0]          stall_cnt
);

   logic [31:0]          rs1_val;
   logic [31:0]          rs2_val;
   logic                 hazard;
   logic                 accept;

   logic                 out_valid_d, out_valid_q;
   logic [31:0]          alu_in1_d, alu_in1_q;
   logic [31:0]          alu_in2_d, alu_in2_q;
   logic [1:0]           alu_op_d, alu_op_q;
   logic [REG_IDX_W-1:0] out_rd_d, out_rd_q;
   logic                 out_wb_en_d, out_wb_en_q;
   logic                 out_is_load_d, out_is_load_q;
   logic [15:0]          stall_cnt_d, stall_cnt_q;

   operand_fwd_mux #(.REG_IDX_W(REG_IDX_W)) u_rs1_mux (
      .rs_idx       (in_rs1),
      .rf_data      (in_rs1_data),
      .fwd_mem_en   (fwd_mem_en),
      .fwd_mem_rd   (fwd_mem_rd),
      .fwd_mem_data (fwd_mem_data),
      .fwd_wb_en    (fwd_wb_en),
      .fwd_wb_rd    (fwd_wb_rd),
      .fwd_wb_data  (fwd_wb_data),
      .operand      (rs1_val)
   );

   operand_fwd_mux #(.REG_IDX_W(REG_IDX_W)) u_rs2_mux (
      .rs_idx       (in_rs2),
      .rf_data      (in_rs2_data),
      .fwd_mem_en   (fwd_mem_en),
      .fwd_mem_rd   (fwd_mem_rd),
      .fwd_mem_data (fwd_mem_data),
      .fwd_wb_en    (fwd_wb_en),
      .fwd_wb_rd    (fwd_wb_rd),
      .fwd_wb_data  (fwd_wb_data),
      .operand      (rs2_val)
   );

   // A load still sitting in this register cannot forward yet, so a dependent
   // instruction must wait one cycle for it to reach MEM.
   always_comb begin
      hazard   = in_valid && out_valid_q && out_is_load_q && out_wb_en_q &&
                 (out_rd_q != '0) &&
                 ((out_rd_q == in_rs1) || ((out_rd_q == in_rs2) && !in_use_imm));
      in_ready = !flush && !hazard && (!out_valid_q || out_ready);
      accept   = in_valid && in_ready;
   end

   always_comb begin
      out_valid_d   = 1'b0;
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      alu_op_d      = alu_op_q;
      out_rd_d      = out_rd_q;
      out_wb_en_d   = out_wb_en_q;
      out_is_load_d = out_is_load_q;
      stall_cnt_d   = stall_cnt_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d   = 1'b1;
         alu_in1_d     = rs1_val;
         alu_in2_d     = in_use_imm ? extend_imm(in_imm, in_sign_ext) : rs2_val;
         alu_op_d      = in_alu_op;
         out_rd_d      = in_rd;
         out_wb_en_d   = in_wb_en;
         out_is_load_d = in_is_load;
      end else if (out_valid_q && !out_ready) begin
         out_valid_d = 1'b1;
      end

      if (hazard && !flush && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         alu_in1_q     <= 32'h0;
         alu_in2_q     <= 32'h0;
         alu_op_q      <= ALU_Add;
         out_rd_q      <= '0;
         out_wb_en_q   <= 1'b0;
         out_is_load_q <= 1'b0;
         stall_cnt_q   <= 16'h0;
      end else begin
         out_valid_q   <= out_valid_d;
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         alu_op_q      <= alu_op_d;
         out_rd_q      <= out_rd_d;
         out_wb_en_q   <= out_wb_en_d;
         out_is_load_q <= out_is_load_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_op      = alu_op_q;
   assign out_rd      = out_rd_q;
   assign out_wb_en   = out_wb_en_q;
   assign out_is_load = out_is_load_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic, all
// checked against a cycle-level behavioural model of the stage.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_alu_op;
   logic [3:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data;
   logic [15:0] in_imm;
   logic        in_use_imm, in_sign_ext, in_wb_en, in_is_load, flush;
   logic        fwd_mem_en, fwd_wb_en;
   logic [3:0]  fwd_mem_rd, fwd_wb_rd;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        out_valid, out_ready;
   logic [31:0] alu_in1, alu_in2;
   logic [1:0]  alu_op;
   logic [3:0]  out_rd;
   logic        out_wb_en, out_is_load;
   logic [15:0] stall_cnt;

   int compared   = 0;
   int mismatched = 0;

   // Expected architectural state of the output register
   logic        m_valid;
   logic [31:0] m_in1, m_in2;
   logic [1:0]  m_op;
   logic [3:0]  m_rd;
   logic        m_wb, m_ld;
   int          m_cnt;

   id_ex_stage #(.REG_IDX_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
      .in_wb_en(in_wb_en), .in_is_load(in_is_load), .flush(flush),
      .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .out_rd(out_rd),
      .out_wb_en(out_wb_en), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] resolve(input logic [3:0] idx, input logic [31:0] rf);
      if (idx == 4'd0) return 32'h0;
      if (fwd_mem_en && fwd_mem_rd == idx) return fwd_mem_data;
      if (fwd_wb_en && fwd_wb_rd == idx) return fwd_wb_data;
      return rf;
   endfunction

   function automatic logic model_hazard();
      logic reads_rd;
      reads_rd = (m_rd == in_rs1) || (!in_use_imm && m_rd == in_rs2);
      return in_valid && m_valid && m_ld && m_wb && (m_rd != 4'd0) && reads_rd;
   endfunction

   task automatic modelReset();
      m_valid = 1'b0; m_in1 = 32'h0; m_in2 = 32'h0; m_op = ALU_Add;
      m_rd = 4'd0; m_wb = 1'b0; m_ld = 1'b0; m_cnt = 0;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".out_valid"},   32'(out_valid),   32'(m_valid));
      checkOutput({tag, ".alu_in1"},     alu_in1,          m_in1);
      checkOutput({tag, ".alu_in2"},     alu_in2,          m_in2);
      checkOutput({tag, ".alu_op"},      32'(alu_op),      32'(m_op));
      checkOutput({tag, ".out_rd"},      32'(out_rd),      32'(m_rd));
      checkOutput({tag, ".out_wb_en"},   32'(out_wb_en),   32'(m_wb));
      checkOutput({tag, ".out_is_load"}, 32'(out_is_load), 32'(m_ld));
      checkOutput({tag, ".stall_cnt"},   32'(stall_cnt),   32'(m_cnt));
   endtask

   task automatic clearInputs();
      in_valid = 0; in_alu_op = ALU_Add; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0; in_sign_ext = 0;
      in_wb_en = 0; in_is_load = 0; flush = 0; out_ready = 1;
      fwd_mem_en = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
      fwd_wb_en = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
   endtask

   // One clock cycle with the currently driven inputs: predict, clock, compare.
   task automatic applyStimulus(input string tag);
      logic        haz, rdy, acc;
      logic [31:0] n1, n2;
      #1;
      haz = model_hazard();
      rdy = !flush && !haz && (!m_valid || out_ready);
      acc = in_valid && rdy;
      checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      n1 = resolve(in_rs1, in_rs1_data);
      if (in_use_imm) n2 = in_sign_ext ? 32'(signed'(in_imm)) : 32'(in_imm);
      else            n2 = resolve(in_rs2, in_rs2_data);
      @(posedge clk);
      if (haz && !flush && m_cnt < 65535) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
         m_valid = 1'b1; m_in1 = n1; m_in2 = n2; m_op = in_alu_op;
         m_rd = in_rd; m_wb = in_wb_en; m_ld = in_is_load;
      end else m_valid = m_valid && !out_ready;
      #1;
      checkAll(tag);
   endtask

   initial begin
      logic [31:0] held1;
      clearInputs();
      modelReset();
      rst_n = 1'b0;
      #12;
      checkAll("reset");
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Plain ADD with register-file operands
      in_valid = 1; in_alu_op = ALU_Add; in_rs1 = 3; in_rs1_data = 5;
      in_rs2 = 4; in_rs2_data = 7; in_rd = 6; in_wb_en = 1;
      applyStimulus("add");
      checkOutput("add.in1_const", alu_in1, 32'd5);
      checkOutput("add.in2_const", alu_in2, 32'd7);

      // Immediate extension, both flavours
      in_use_imm = 1; in_imm = 16'hFFFE; in_sign_ext = 1;
      applyStimulus("imm_sext");
      checkOutput("imm_sext.const", alu_in2, 32'hFFFFFFFE);
      in_sign_ext = 0;
      applyStimulus("imm_zext");
      checkOutput("imm_zext.const", alu_in2, 32'h0000FFFE);

      // Forwarding priority and R0
      in_use_imm = 0; in_rs1 = 2; in_rs1_data = 32'hC;
      fwd_mem_en = 1; fwd_mem_rd = 2; fwd_mem_data = 32'hA;
      fwd_wb_en = 1; fwd_wb_rd = 2; fwd_wb_data = 32'hB;
      applyStimulus("fwd_prio");
      checkOutput("fwd_prio.const", alu_in1, 32'hA);
      in_rs1 = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
      applyStimulus("fwd_r0");
      checkOutput("fwd_r0.const", alu_in1, 32'h0);
      fwd_mem_en = 0; fwd_wb_en = 0;
      in_alu_op = 2'd3;
      applyStimulus("op_unused");
      checkOutput("op_unused.const", 32'(alu_op), 32'd3);

      // Load-use: load to r5, then a consumer of r5
      in_alu_op = ALU_Add; in_rd = 5; in_is_load = 1; in_wb_en = 1; in_rs1 = 1;
      applyStimulus("ld");
      in_is_load = 0; in_rd = 7; in_rs1 = 5; in_rs1_data = 32'h55;
      #1 checkOutput("lu.in_ready_low", 32'(in_ready), 32'd0);
      applyStimulus("lu_bubble");
      checkOutput("lu.bubble", 32'(out_valid), 32'd0);
      checkOutput("lu.stall1", 32'(stall_cnt), 32'd1);
      applyStimulus("lu_accept");
      checkOutput("lu.accepted", 32'(out_valid), 32'd1);

      // Backpressure hold, then flush, then async reset mid-hold
      out_ready = 0; in_rs1 = 9;
      held1 = alu_in1;
      for (int i = 0; i < 3; i++) applyStimulus("hold");
      checkOutput("hold.in1_stable", alu_in1, held1);
      flush = 1;
      applyStimulus("flush");
      checkOutput("flush.valid", 32'(out_valid), 32'd0);
      flush = 0; out_ready = 1;
      applyStimulus("refill");
      out_ready = 0;
      applyStimulus("hold2");
      rst_n = 1'b0;
      #1;
      modelReset();
      checkAll("rst_mid");
      #2 rst_n = 1'b1;
      out_ready = 1;
      applyStimulus("post_rst");

      // Random traffic over a small register window so hazards and matches are common
      for (int i = 0; i < 400; i++) begin
         in_valid     = ($urandom_range(0, 4) != 0);
         in_alu_op    = 2'($urandom_range(0, 3));
         in_rs1       = 4'($urandom_range(0, 3));
         in_rs2       = 4'($urandom_range(0, 3));
         in_rd        = 4'($urandom_range(0, 3));
         in_rs1_data  = $urandom;
         in_rs2_data  = $urandom;
         in_imm       = 16'($urandom);
         in_use_imm   = $urandom_range(0, 1) == 1;
         in_sign_ext  = $urandom_range(0, 1) == 1;
         in_wb_en     = $urandom_range(0, 3) != 0;
         in_is_load   = $urandom_range(0, 1) == 1;
         flush        = $urandom_range(0, 15) == 0;
         out_ready    = $urandom_range(0, 3) != 0;
         fwd_mem_en   = $urandom_range(0, 1) == 1;
         fwd_mem_rd   = 4'($urandom_range(0, 3));
         fwd_mem_data = $urandom;
         fwd_wb_en    = $urandom_range(0, 1) == 1;
         fwd_wb_rd    = 4'($urandom_range(0, 3));
         fwd_wb_data  = $urandom;
         applyStimulus("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: REG_IDX_W, default 4, register-index width (16 architectural registers, R0 reads zero).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  decode stage presents an instruction; in_ready  output  1  stage accepts it this cycle.
REQ-005 in_alu_op  input  2  ALU select (ALU_Add/ALU_Sub/ALU_And); in_rs1, in_rs2, in_rd  input  REG_IDX_W  source/dest indices.
REQ-006 in_rs1_data, in_rs2_data  input  32  register-file read data; in_imm  input  16  immediate; in_use_imm  input  1  operand 2 is immediate; in_sign_ext  input  1  sign- vs zero-extend imm.
REQ-007 in_wb_en  input  1  instruction writes rd; in_is_load  input  1  instruction is a load.
REQ-008 flush  input  1  kill pending and in-flight instruction (branch redirect).
REQ-009 fwd_mem_en, fwd_wb_en  input  1; fwd_mem_rd, fwd_wb_rd  input  REG_IDX_W; fwd_mem_data, fwd_wb_data  input  32  forwarding from MEM and WB stages.
REQ-010 out_valid  output  1; out_ready  input  1  execute-stage handshake.
REQ-011 alu_in1, alu_in2  output  32; alu_op  output  2; out_rd  output  REG_IDX_W; out_wb_en, out_is_load  output  1  registered operands/controls feeding the ALU.
REQ-012 stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-013 Operand resolve (combinational, per source): index 0 -> 0; else fwd_mem match (en & rd equal) -> fwd_mem_data; else fwd_wb match -> fwd_wb_data; else in_rsN_data.
REQ-014 alu_in2 source: in_use_imm=1 -> in_imm extended to 32 bits (sign if in_sign_ext, else zero); else resolved rs2.
REQ-015 hazard = in_valid & out_valid & out_is_load & out_wb_en & out_rd!=0 & (out_rd==in_rs1 | (out_rd==in_rs2 & !in_use_imm)).
REQ-016 in_ready = !flush & !hazard & (!out_valid | out_ready).
REQ-017 Accept (in_valid & in_ready): output register loads resolved operands and controls; out_valid=1 next cycle; latency exactly 1 cycle.
REQ-018 No accept and (out_ready | !out_valid | hazard-with-out_ready): out_valid=0 next cycle (bubble); held payload unchanged.
REQ-019 out_valid & !out_ready: all outputs held stable; in_ready=0.
REQ-020 flush: out_valid=0 next cycle regardless of other inputs; input not accepted; stall_cnt not incremented.
REQ-021 stall_cnt increments by 1 each cycle hazard=1 & !flush, saturating at 0xFFFF.
REQ-022 Simultaneous fwd_mem and fwd_wb match on same index: fwd_mem wins.
REQ-023 Unused alu_op encoding passes through unchanged.

Reset
REQ-024 rst_n low: out_valid=0, alu_in1=0, alu_in2=0, alu_op=ALU_Add, out_rd=0, out_wb_en=0, out_is_load=0, stall_cnt=0, immediately (asynchronous).
REQ-025 Reset mid-transfer: in-flight instruction discarded; first accept possible on first clk edge after rst_n rises.

Structure
REQ-026 ALU_Add=2'd0, ALU_Sub=2'd1, ALU_And=2'd2 and REG_IDX_W default live in shared constants package; id_ex_stage references them, defines none.
REQ-027 One sub-module, operand_fwd_mux (REQ-013 priority mux), instantiated twice.

Verification
REQ-028 Accept ADD rs1=3 (data 5), rs2=4 (data 7), out_ready=1 -> next cycle out_valid=1, alu_in1=5, alu_in2=7, alu_op=ALU_Add.
REQ-029 in_imm=16'hFFFE, in_use_imm=1: in_sign_ext=1 -> alu_in2=32'hFFFFFFFE; in_sign_ext=0 -> 32'h0000FFFE.
REQ-030 rs1=2, fwd_mem rd=2 data=0xA, fwd_wb rd=2 data=0xB, regfile 0xC -> alu_in1=0xA; rs1=0 with all matching -> alu_in1=0.
REQ-031 Load to r5 in output reg, next instr reads r5 -> in_ready=0 one cycle, bubble issued, stall_cnt=1, then accepted.
REQ-032 out_ready=0 for 3 cycles -> outputs stable, in_ready=0; flush asserted -> out_valid=0 next cycle; rst_n pulse mid-hold -> all outputs reset values immediately.
